// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad event controller: FSM encoding,
// event layout and one-hot decode helpers.
package keypad_pkg;

  localparam int unsigned KEY_CODE_W = 4;
  localparam logic [KEY_CODE_W-1:0] NO_KEY = 4'b0000;
  localparam int unsigned EVT_W = KEY_CODE_W + 1;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    HELD         = 2'd1,
    REPEAT       = 2'd2,
    RELEASE_WAIT = 2'd3
  } kp_state_e;

  typedef struct packed {
    logic [KEY_CODE_W-1:0] code;
    logic                  rpt;
  } key_event_t;

  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
  endfunction

  // Only meaningful when v is one-hot; the highest set bit wins otherwise.
  function automatic logic [1:0] onehot4_idx(input logic [3:0] v);
    logic [1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (v[i]) idx = i[1:0];
    end
    return idx;
  endfunction

endpackage

// File: rtl/key_event_fifo.sv
// First-word-fall-through event queue with full/empty flags and
// simultaneous push/pop; a push into a full queue only lands alongside a pop.
module key_event_fifo #(
  parameter int unsigned WIDTH = 5,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == DEPTH_C);
  assign empty_o = (count_q == '0);
  assign rdata_o = mem_q[rptr_q];

  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_ok) wptr_d = wptr_q + AW'(1);
    if (pop_ok)  rptr_d = rptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/keypad_event_controller.sv
// Turns the poller's held-key flag and one-hot row/column into queued key
// events, with optional auto-repeat and a sticky overflow flag.
module keypad_event_controller
  import keypad_pkg::*;
#(
  parameter logic [15:0] REPEAT_DELAY  = 16'd24000,
  parameter logic [15:0] REPEAT_PERIOD = 16'd6000,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  key_pressed,
  input  logic [3:0]            row_in,
  input  logic [3:0]            col_in,
  input  logic                  repeat_en,
  input  logic                  key_ready,
  input  logic                  clear_overflow,
  output logic                  key_valid,
  output logic [KEY_CODE_W-1:0] key_code,
  output logic                  key_repeat,
  output logic                  overflow
);

  localparam logic [15:0] DELAY_LAST  = REPEAT_DELAY - 16'd1;
  localparam logic [15:0] PERIOD_LAST = REPEAT_PERIOD - 16'd1;

  kp_state_e             state_q, state_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [KEY_CODE_W-1:0] code_q, code_d;
  logic                  kp_q;
  logic                  overflow_q, overflow_d;

  logic                  rise, key_ok;
  logic [KEY_CODE_W-1:0] new_code;
  logic                  wr_en;
  key_event_t            wr_evt, head_evt;
  logic                  fifo_full, fifo_empty;
  logic                  pop, drop;

  assign rise     = key_pressed & ~kp_q;
  assign key_ok   = is_onehot4(row_in) & is_onehot4(col_in);
  assign new_code = {onehot4_idx(row_in), onehot4_idx(col_in)};

  // A release in the same cycle as a timer expiry takes the release branch
  // first, so that repeat write never happens.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    wr_en   = 1'b0;
    wr_evt  = '{code: code_q, rpt: 1'b1};
    case (state_q)
      IDLE: begin
        if (rise) begin
          cnt_d = '0;
          if (key_ok) begin
            code_d  = new_code;
            wr_en   = 1'b1;
            wr_evt  = '{code: new_code, rpt: 1'b0};
            state_d = HELD;
          end else begin
            state_d = RELEASE_WAIT;
          end
        end
      end
      HELD: begin
        if (!key_pressed) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (!repeat_en) begin
          cnt_d = '0;
        end else if (cnt_q == DELAY_LAST) begin
          wr_en   = 1'b1;
          cnt_d   = '0;
          state_d = REPEAT;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      REPEAT: begin
        if (!key_pressed) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (!repeat_en) begin
          cnt_d   = '0;
          state_d = HELD;
        end else if (cnt_q == PERIOD_LAST) begin
          wr_en = 1'b1;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RELEASE_WAIT: begin
        if (!key_pressed) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign pop  = key_valid & key_ready;
  assign drop = wr_en & fifo_full & ~pop;

  always_comb begin
    overflow_d = overflow_q;
    if (drop)                overflow_d = 1'b1;
    else if (clear_overflow) overflow_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      code_q     <= NO_KEY;
      kp_q       <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      code_q     <= code_d;
      kp_q       <= key_pressed;
      overflow_q <= overflow_d;
    end
  end

  key_event_fifo #(
    .WIDTH (EVT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (wr_en),
    .wdata_i (wr_evt),
    .pop_i   (pop),
    .rdata_o (head_evt),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Storage is not reset, so outputs are forced to NO_KEY while empty.
  assign key_valid  = ~fifo_empty;
  assign key_code   = fifo_empty ? NO_KEY : head_evt.code;
  assign key_repeat = fifo_empty ? 1'b0 : head_evt.rpt;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_keypad_event_controller.sv
// Scoreboard bench: stimulus pushes expected events, a negedge monitor pops
// and compares them whenever the DUT hands an event to the consumer.
module tb_keypad_event_controller;
  import keypad_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       key_pressed;
  logic [3:0] row_in, col_in;
  logic       repeat_en, key_ready, clear_overflow;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_repeat;
  logic       overflow;

  typedef struct {
    logic [3:0]  code;
    logic        rpt;
    bit          chk_t;
    int unsigned t;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned n_chk = 0;
  int unsigned n_fail = 0;
  int unsigned cyc = 0;
  int unsigned t0;

  keypad_event_controller #(
    .REPEAT_DELAY  (16'd10),
    .REPEAT_PERIOD (16'd4),
    .FIFO_DEPTH    (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .key_pressed    (key_pressed),
    .row_in         (row_in),
    .col_in         (col_in),
    .repeat_en      (repeat_en),
    .key_ready      (key_ready),
    .clear_overflow (clear_overflow),
    .key_valid      (key_valid),
    .key_code       (key_code),
    .key_repeat     (key_repeat),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [3:0] code, input logic rpt, input bit chk_t, input int unsigned t);
    exp_t e;
    e.code = code; e.rpt = rpt; e.chk_t = chk_t; e.t = t;
    exp_q.push_back(e);
  endtask

  task automatic press(input logic [3:0] r, input logic [3:0] c, input int unsigned hold);
    row_in = r; col_in = c; key_pressed = 1'b1;
    tick(hold);
    key_pressed = 1'b0;
    tick(2);
  endtask

  // Monitor: a transfer happens at the next posedge when valid and ready.
  always @(negedge clk) begin
    if (reset === 1'b1 && key_valid === 1'b1 && key_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_event: got code=0x%0h rpt=%0b expected none (cycle %0d)",
                 key_code, key_repeat, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("event_code_rpt", 32'({key_code, key_repeat}), 32'({e.code, e.rpt}));
        if (e.chk_t) check("event_cycle", cyc, e.t);
      end
    end
  end

  initial begin
    reset = 1'b0; key_pressed = 1'b0; row_in = '0; col_in = '0;
    repeat_en = 1'b0; key_ready = 1'b1; clear_overflow = 1'b0;

    // Reset values
    tick(2);
    check("rst_key_valid", 32'(key_valid), 32'd0);
    check("rst_key_code", 32'(key_code), 32'd0);
    check("rst_key_repeat", 32'(key_repeat), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    reset = 1'b1;
    tick(2);

    // Single press, code 9; long hold with repeat disabled gives no repeats
    row_in = 4'b0100; col_in = 4'b0010; key_pressed = 1'b1;
    t0 = cyc;
    push_exp(4'h9, 1'b0, 1'b1, t0 + 1);
    check("valid_before_edge", 32'(key_valid), 32'd0);
    tick(1);
    check("valid_after_write", 32'(key_valid), 32'd1);
    check("head_code_9", 32'(key_code), 32'h9);
    tick(15);
    key_pressed = 1'b0;
    tick(4);

    // Auto-repeat: first at +1, repeats at +11,+15,+19,+23,+27; row/col change ignored
    repeat_en = 1'b1;
    row_in = 4'b0001; col_in = 4'b1000; key_pressed = 1'b1;
    t0 = cyc;
    push_exp(4'h3, 1'b0, 1'b1, t0 + 1);
    push_exp(4'h3, 1'b1, 1'b1, t0 + 11);
    push_exp(4'h3, 1'b1, 1'b1, t0 + 15);
    push_exp(4'h3, 1'b1, 1'b1, t0 + 19);
    push_exp(4'h3, 1'b1, 1'b1, t0 + 23);
    push_exp(4'h3, 1'b1, 1'b1, t0 + 27);
    tick(5);
    row_in = 4'b1000; col_in = 4'b0001;
    tick(25);
    key_pressed = 1'b0;
    tick(8);
    check("idle_after_repeat", 32'(dut.state_q), 32'(IDLE));

    // Invalid row pattern at the rise: no event, wait for release
    row_in = 4'b0110; col_in = 4'b0010; key_pressed = 1'b1;
    tick(2);
    check("release_wait_state", 32'(dut.state_q), 32'(RELEASE_WAIT));
    row_in = 4'b0010;
    tick(12);
    check("no_event_invalid", 32'(key_valid), 32'd0);
    key_pressed = 1'b0;
    tick(1);
    check("idle_after_invalid", 32'(dut.state_q), 32'(IDLE));
    repeat_en = 1'b0;
    tick(2);

    // Fill the queue with the consumer stalled; fifth press is dropped
    key_ready = 1'b0;
    push_exp(4'h0, 1'b0, 1'b0, 0); press(4'b0001, 4'b0001, 2);
    push_exp(4'h6, 1'b0, 1'b0, 0); press(4'b0010, 4'b0100, 2);
    push_exp(4'hD, 1'b0, 1'b0, 0); press(4'b1000, 4'b0010, 2);
    push_exp(4'hB, 1'b0, 1'b0, 0); press(4'b0100, 4'b1000, 2);
    check("no_overflow_at_full", 32'(overflow), 32'd0);
    press(4'b0010, 4'b0001, 2);
    check("overflow_set", 32'(overflow), 32'd1);
    check("head_stable_stalled", 32'({key_valid, key_code}), 32'h10);

    // Drop and clear in the same cycle: overflow stays set
    row_in = 4'b0001; col_in = 4'b0100; key_pressed = 1'b1; clear_overflow = 1'b1;
    tick(1);
    clear_overflow = 1'b0;
    check("drop_beats_clear", 32'(overflow), 32'd1);
    key_pressed = 1'b0;
    tick(2);
    clear_overflow = 1'b1;
    tick(1);
    clear_overflow = 1'b0;
    check("overflow_cleared", 32'(overflow), 32'd0);

    // Full queue: pop coincides with a new press, which must be accepted
    row_in = 4'b1000; col_in = 4'b1000; key_pressed = 1'b1; key_ready = 1'b1;
    push_exp(4'hF, 1'b0, 1'b0, 0);
    tick(1);
    key_ready = 1'b0;
    check("no_drop_on_pop", 32'(overflow), 32'd0);
    check("head_after_pop", 32'(key_code), 32'h6);
    key_pressed = 1'b0;
    tick(2);
    press(4'b0100, 4'b0100, 2);
    check("still_full", 32'(overflow), 32'd1);
    clear_overflow = 1'b1;
    tick(1);
    clear_overflow = 1'b0;
    key_ready = 1'b1;
    tick(8);
    check("drained", 32'(key_valid), 32'd0);

    // Reset mid-repeat with two events queued
    key_ready = 1'b0; repeat_en = 1'b1;
    row_in = 4'b0010; col_in = 4'b0010; key_pressed = 1'b1;
    tick(13);
    check("two_queued_valid", 32'(key_valid), 32'd1);
    check("in_repeat_state", 32'(dut.state_q), 32'(REPEAT));
    reset = 1'b0;
    tick(1);
    check("mid_rst_valid", 32'(key_valid), 32'd0);
    check("mid_rst_code", 32'(key_code), 32'd0);
    reset = 1'b1; key_ready = 1'b1;
    t0 = cyc;
    push_exp(4'h5, 1'b0, 1'b1, t0 + 1);
    tick(4);
    key_pressed = 1'b0; repeat_en = 1'b0;
    tick(6);

    check("missing_events", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
